// File: rtl/a2d_spi_resp.sv
// SPI slave emulating an A2D converter: a 16-bit frame commands a channel,
// the next frame returns that channel's 12-bit conversion result.
module a2d_spi_resp #(
  parameter logic [11:0] INIT_RESULT = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  cnv_chnnl,
  output logic        cnv_req,
  input  logic [11:0] cnv_data,
  output logic        frm_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE,
    CAPTURE
  } state_t;

  state_t state, state_n;

  logic [2:0]  ss_q, sclk_q;
  logic [1:0]  mosi_q;
  logic        rdy, arm;
  logic [15:0] tx, tx_n;
  logic [15:0] rx, rx_n;
  logic [4:0]  bit_cnt, cnt_n;
  logic [11:0] result, res_n;
  logic [2:0]  chn_n;
  logic        req_n, err_n;
  logic        pend, pend_n;

  logic ss_fall, ss_rise;
  logic sclk_rise, sclk_fall;
  logic mosi_s;

  // arm stays low until SS_n is seen high after reset,
  // so a frame already in progress at release is skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      rdy    <= 1'b0;
      arm    <= 1'b0;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
      rdy    <= 1'b1;
      arm    <= arm | (rdy & ss_q[0]);
    end
  end

  assign ss_fall   = arm & ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign mosi_s    = mosi_q[1];

  assign MISO = ~ss_q[1] & tx[15];

  always_comb begin
    state_n = state;
    tx_n    = tx;
    rx_n    = rx;
    cnt_n   = bit_cnt;
    res_n   = result;
    chn_n   = cnv_chnnl;
    req_n   = 1'b0;
    err_n   = 1'b0;
    pend_n  = pend;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          tx_n    = {4'b0000, result};
          cnt_n   = 5'd0;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          if (bit_cnt == 5'd16) begin
            chn_n   = rx[13:11];
            req_n   = 1'b1;
            state_n = DONE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (sclk_rise) begin
          rx_n = {rx[14:0], mosi_s};
          if (bit_cnt != 5'd17)
            cnt_n = bit_cnt + 5'd1;
        end else if (sclk_fall && bit_cnt != 5'd0) begin
          tx_n = {tx[14:0], 1'b0};
        end
      end
      DONE: begin
        if (ss_fall)
          pend_n = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: begin
        res_n  = cnv_data;
        pend_n = 1'b0;
        // a frame that started early gets the fresh result
        if (pend || ss_fall) begin
          tx_n    = {4'b0000, cnv_data};
          cnt_n   = 5'd0;
          state_n = ACTIVE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 16'h0000;
      rx        <= 16'h0000;
      bit_cnt   <= 5'd0;
      result    <= INIT_RESULT;
      cnv_chnnl <= 3'd0;
      cnv_req   <= 1'b0;
      frm_err   <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state     <= state_n;
      tx        <= tx_n;
      rx        <= rx_n;
      bit_cnt   <= cnt_n;
      result    <= res_n;
      cnv_chnnl <= chn_n;
      cnv_req   <= req_n;
      frm_err   <= err_n;
      pend      <= pend_n;
    end
  end

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 SHALL have parameter INIT_RESULT, default 12'h000: result value returned in the first frame after reset.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port SS_n, input, 1 bit: active-low slave select from the A2D SPI master; asynchronous to clk.
REQ-005 SHALL have port SCLK, input, 1 bit: SPI serial clock from the master; asynchronous to clk; period at least 8 clk cycles.
REQ-006 SHALL have port MOSI, input, 1 bit: command data from the master, MSB first.
REQ-007 SHALL have port MISO, output, 1 bit: response data to the master, MSB first.
REQ-008 SHALL have port cnv_chnnl, output, 3 bits: channel latched from the last good frame.
REQ-009 SHALL have port cnv_req, output, 1 bit: one-clk pulse requesting a conversion of cnv_chnnl.
REQ-010 SHALL have port cnv_data, input, 12 bits: conversion value, sampled one clk after cnv_req.
REQ-011 SHALL have port frm_err, output, 1 bit: one-clk pulse when a frame ends without exactly 16 SCLK rises.

Function
REQ-012 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronizers, plus one history flop each for SS_n and SCLK for edge detection.
REQ-013 SHALL form all edges from synchronized signals only; a raw input change appears as an edge 3 clks later.
REQ-014 SHALL implement states IDLE, ACTIVE, DONE and CAPTURE.
REQ-015 SHALL, in IDLE on an SS_n fall, load the 16-bit tx shift register with {4'b0000, result}, clear bit_cnt, and go to ACTIVE.
REQ-016 SHALL drive MISO from tx[15] while synchronized SS_n is low, and drive 0 otherwise.
REQ-017 SHALL, in ACTIVE on each SCLK rise, shift synchronized MOSI into the LSB of the 16-bit rx register and increment bit_cnt; bit_cnt saturates at 17.
REQ-018 SHALL, in ACTIVE on each SCLK fall where bit_cnt is not 0, shift tx left by one and fill with 0 (SPI mode 0).
REQ-019 SHALL ignore any SCLK fall that occurs before the first SCLK rise.
REQ-020 SHALL, in ACTIVE on an SS_n rise with bit_cnt == 16, set cnv_chnnl = rx[13:11] and go to DONE.
REQ-021 SHALL, in ACTIVE on an SS_n rise with bit_cnt != 16, pulse frm_err, leave cnv_chnnl and result unchanged, and go to IDLE.
REQ-022 SHALL, in DONE, assert cnv_req for exactly one clk and go to CAPTURE.
REQ-023 SHALL, in CAPTURE, load result = cnv_data and go to IDLE.
REQ-024 SHALL, when an SS_n fall occurs in DONE or CAPTURE, complete the result update first and then load tx with the updated result.
REQ-025 SHALL, when SS_n and SCLK edges are detected in the same clk, act on the SS_n edge only.
REQ-026 SHALL make each frame return the conversion of the channel commanded in the previous good frame, i.e. a one-frame pipeline.
REQ-027 SHALL ignore rx bits [15:14] and [10:0].

Reset
REQ-028 SHALL, while rst is high at a clk edge, set state=IDLE, tx=0, rx=0, bit_cnt=0, result=INIT_RESULT, cnv_chnnl=0, cnv_req=0, frm_err=0, and MISO=0.
REQ-029 SHALL initialize all synchronizer flops for SS_n to 1 and for SCLK and MOSI to 0, so that no edge is detected on reset release.
REQ-030 SHALL, when rst is asserted mid-frame, abort the frame silently with no frm_err and no cnv_req.
REQ-031 SHALL, after reset is released with SS_n already low, ignore the remainder of that frame and wait for the next SS_n fall.

Verification
REQ-032 SHALL cover: reset, then frame MOSI=16'h1800 -> MISO returns 16'h0000, cnv_chnnl=3, one cnv_req pulse.
REQ-033 SHALL cover: cnv_data=12'hABC held at cnv_req, then next frame -> MISO returns 16'h0ABC MSB first, with bit 15 valid before the first SCLK rise.
REQ-034 SHALL cover: SS_n raised after 9 SCLK rises -> frm_err pulses once, no cnv_req, and the next frame still returns the prior result.
REQ-035 SHALL cover: 17 SCLK rises in one frame -> frm_err, and cnv_chnnl unchanged.
REQ-036 SHALL cover: rst asserted after 8 bits -> MISO=0, no pulses, and result=INIT_RESULT afterwards.
REQ-037 SHALL cover: back-to-back frames with SS_n high for 2 clks -> the second frame carries the data captured from the first frame's request.
